// File: rtl/sr_pulse_driver_pkg.sv
// Shared types and helpers for the SR latch pulse driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } sr_state_e;

    localparam int DEF_PULSE_W = 4;
    localparam int DEF_GAP_W   = 2;

    // Maps a target latch value to {s,r}; 2'b11 is unreachable by construction.
    function automatic logic [1:0] sr_encode(input logic tgt);
        return tgt ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Command handshake between control logic and the SR pulse driver.
interface sr_pulse_driver_if;
    logic cmd_valid;
    logic cmd_val;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_val, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_val, output cmd_ready);
endinterface

// File: rtl/sr_pulse_driver_timer.sv
// Loadable down-counter that stops at zero; times the pulse and gap phases.
module sr_pulse_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    assign zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && !zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sr_pulse_driver.sv
// SR latch pulse driver: turns accepted commands into timed s/r pulses plus a gap.
// Optional build macro SR_DRV_SKIP_EN skips commands matching a known latch state.
module sr_pulse_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    sr_pulse_driver_if.slave    cmd,
    output logic                s,
    output logic                r,
    output logic                q_model,
    output logic                q_known,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

    sr_state_e        r_state, w_state_n;
    logic             r_tgt, w_tgt_n;
    logic [1:0]       r_sr, w_sr_n;
    logic             r_qm, w_qm_n;
    logic             r_qk, w_qk_n;
    logic             r_done, w_done_n;
    logic             w_accept, w_skip, w_zero, w_load, w_dec;
    logic [CNT_W-1:0] w_load_val;

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    assign cmd.cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

`ifdef SR_DRV_SKIP_EN
    assign w_skip = r_qk && (cmd.cmd_val == r_qm);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_tgt_n    = r_tgt;
        w_qm_n     = r_qm;
        w_qk_n     = r_qk;
        w_done_n   = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_skip) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_tgt_n    = cmd.cmd_val;
                        w_load     = 1'b1;
                        w_load_val = PULSE_LOAD;
                        w_state_n  = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (w_zero) begin
                    w_qm_n = r_tgt;
                    w_qk_n = 1'b1;
                    if (GAP_W == 0) begin
                        w_done_n  = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_load     = 1'b1;
                        w_load_val = GAP_LOAD;
                        w_state_n  = ST_GAP;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        // s/r are registered, so they follow the state being entered.
        w_sr_n = (w_state_n == ST_PULSE) ? sr_encode(w_tgt_n) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= 1'b0;
            r_sr    <= 2'b00;
            r_qm    <= 1'b0;
            r_qk    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tgt   <= w_tgt_n;
            r_sr    <= w_sr_n;
            r_qm    <= w_qm_n;
            r_qk    <= w_qk_n;
            r_done  <= w_done_n;
        end
    end

    assign s       = r_sr[1];
    assign r       = r_sr[0];
    assign q_model = r_qm;
    assign q_known = r_qk;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed vector bench for sr_pulse_driver with PULSE_W=4, GAP_W=2.
module tb_sr_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s, r, q_model, q_known, busy, done;
    int   checks = 0;
    int   failures = 0;

    sr_pulse_driver_if cmd_if ();

    sr_pulse_driver #(.PULSE_W(4), .GAP_W(2), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .s       (s),
        .r       (r),
        .q_model (q_model),
        .q_known (q_known),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Fields: rst v val | s r | rdy done qm qk busy
    typedef struct packed {
        logic rst, v, val;
        logic s, r;
        logic rdy, d, qm, qk, b;
    } vec_t;

    vec_t tbl [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (s === 1'b1 && r === 1'b1) begin
            failures++;
            $display("FAIL s_and_r: got s=1 r=1 expected never both at %0t", $time);
        end
    end

    initial begin
        int n;
        tbl[0]  = 10'b100_00_00000;
        tbl[1]  = 10'b000_00_10000;
        tbl[2]  = 10'b011_10_00001;
        tbl[3]  = 10'b010_10_00001;
        tbl[4]  = 10'b011_10_00001;
        tbl[5]  = 10'b010_10_00001;
        tbl[6]  = 10'b000_00_00111;
        tbl[7]  = 10'b000_00_00111;
        tbl[8]  = 10'b000_00_11110;
        tbl[9]  = 10'b010_01_00111;
        tbl[10] = 10'b000_01_00111;
        tbl[11] = 10'b000_01_00111;
        tbl[12] = 10'b000_01_00111;
        tbl[13] = 10'b000_00_00011;
        tbl[14] = 10'b000_00_00011;
        tbl[15] = 10'b000_00_11010;
        tbl[16] = 10'b000_00_10010;

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_val   = 1'b0;
        #2;

        for (int i = 0; i < 17; i++) begin
            rst              = tbl[i].rst;
            cmd_if.cmd_valid = tbl[i].v;
            cmd_if.cmd_val   = tbl[i].val;
            step();
            chk($sformatf("row%0d_s", i),     int'(s),                int'(tbl[i].s));
            chk($sformatf("row%0d_r", i),     int'(r),                int'(tbl[i].r));
            chk($sformatf("row%0d_ready", i), int'(cmd_if.cmd_ready), int'(tbl[i].rdy));
            chk($sformatf("row%0d_done", i),  int'(done),             int'(tbl[i].d));
            chk($sformatf("row%0d_qm", i),    int'(q_model),          int'(tbl[i].qm));
            chk($sformatf("row%0d_qk", i),    int'(q_known),          int'(tbl[i].qk));
            chk($sformatf("row%0d_busy", i),  int'(busy),             int'(tbl[i].b));
        end

        // Reset asserted during the second pulse cycle.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_val   = 1'b1;
        step();
        chk("abort_p1_s", int'(s), 1);
        cmd_if.cmd_valid = 1'b0;
        step();
        chk("abort_p2_s", int'(s), 1);
        rst = 1'b1;
        step();
        chk("abort_s", int'(s), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_qk", int'(q_known), 0);
        chk("abort_qm", int'(q_model), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_nodone", int'(done), 0);
            chk("abort_idle_s", int'(s), 0);
        end

        // First command after reset is always pulsed; repeat is skipped only with the macro.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_val   = 1'b1;
        step();
        chk("post_rst_s", int'(s), 1);
        cmd_if.cmd_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("latency", n, 7);
        chk("set_qm", int'(q_model), 1);
        chk("set_qk", int'(q_known), 1);
        chk("set_ready", int'(cmd_if.cmd_ready), 1);

        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_val   = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
`ifdef SR_DRV_SKIP_EN
        chk("repeat_s", int'(s), 0);
        chk("repeat_done", int'(done), 1);
        chk("repeat_ready", int'(cmd_if.cmd_ready), 1);
        chk("repeat_busy", int'(busy), 0);
        step();
        chk("repeat_done_once", int'(done), 0);
`else
        chk("repeat_s", int'(s), 1);
        chk("repeat_done", int'(done), 0);
        chk("repeat_ready", int'(cmd_if.cmd_ready), 0);
        chk("repeat_busy", int'(busy), 1);
        step();
        chk("repeat_s2", int'(s), 1);
`endif
        for (int i = 0; i < 10; i++) step();
        chk("final_idle", int'(busy), 0);
        chk("final_qm", int'(q_model), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Clocked command-side driver for the gated SR latch. It accepts target bit values over a valid/ready handshake and turns each into a timed set or reset pulse on `s`/`r`, followed by an idle gap. It never drives the forbidden `s=r=1` combination. It sits between control logic and the `SRLatch` instance, driving its `s`/`r` inputs, and keeps a model of the latch output.

## Interface
Parameters:
- `PULSE_W`, default 4: cycles `s` or `r` is held high per command; legal range ≥1.
- `GAP_W`, default 2: cycles `s=r=0` after each pulse; legal range ≥0.
- `CNT_W`, default 8: width of the internal down-counter; must hold max(PULSE_W, GAP_W)-1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_val` in 1: target latch value (1 = set, 0 = reset).
- `cmd_ready` out 1: driver can accept a command this cycle.
- `s` out 1: set drive to the latch; registered.
- `r` out 1: reset drive to the latch; registered.
- `q_model` out 1: modelled latch state.
- `q_known` out 1: `q_model` is valid, meaning at least one pulse has completed since reset.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when a command finishes or is skipped.

## Operation
- FSM states and transitions:
  - IDLE: `cmd_ready=1`. On accept (`cmd_valid & cmd_ready`), latch `cmd_val` into `tgt`, load the counter with PULSE_W-1, and go to PULSE.
  - PULSE: `s=tgt`, `r=~tgt`. The counter decrements each cycle. At counter 0:
    - set `q_model=tgt` and `q_known=1`;
    - if GAP_W=0, go to IDLE with `done=1`;
    - otherwise load the counter with GAP_W-1 and go to GAP.
  - GAP: `s=r=0`. At counter 0, go to IDLE and assert `done=1` for one cycle.
- `cmd_ready` = (state==IDLE) & ~`rst`. Inputs are ignored outside IDLE.
- Invariant: `s & r` is never 1, in any cycle including reset.
- `cmd_val` is sampled only on the accept edge. Later changes have no effect on the command in flight.
- Reset values: state IDLE, `s=0`, `r=0`, `q_model=0`, `q_known=0`, `done=0`, counter 0.
- Reset mid-operation: the pulse is aborted, `s=r=0` from the next edge, and `q_known` is cleared. `q_model` is not updated from the aborted command.
- A command equal to the current `q_model` is still pulsed, unless the skip feature below is compiled in.

## Timing
- Accept at edge k:
  - `s`/`r` are high during cycles k+1 … k+PULSE_W;
  - the gap occupies cycles k+PULSE_W+1 … k+PULSE_W+GAP_W;
  - `done=1` and `cmd_ready=1` in cycle k+PULSE_W+GAP_W+1.
- Latency from accept to `done` is PULSE_W+GAP_W+1 cycles.
- Back-to-back commands: a new command can be accepted in the `done` cycle. Peak throughput is 1 command per PULSE_W+GAP_W+1 cycles.
- `q_model` updates on the same edge as the last pulse cycle, so it is visible in the first gap cycle.
- `done` is never asserted in two consecutive cycles for a single command.

## Configuration
- `SR_DRV_SKIP_EN` defined: on accept with `q_known=1` and `cmd_val==q_model`:
  - no pulse is issued and the FSM stays in IDLE;
  - `done=1` in the next cycle;
  - `cmd_ready` stays 1.
- With `q_known=0`, every command is pulsed.
- `SR_DRV_SKIP_EN` undefined: every accepted command is pulsed. `q_known` is still produced.

## Structure
- `sr_drv_pkg` holds:
  - the state enum (IDLE, PULSE, GAP);
  - localparams for the default PULSE_W/GAP_W;
  - the `s`/`r` encoding function (target → {s,r}, which never returns 2'b11).
- One sub-module, `sr_pulse_timer`: a loadable down-counter with `load`, `load_val`, and `zero` outputs, parameterised by CNT_W. The FSM stays in the top module.

## Test plan
All scenarios use PULSE_W=4, GAP_W=2.
- Reset, then hold idle → `s=r=0`, `q_model=0`, `q_known=0`, `cmd_ready=1` from the first post-reset cycle.
- Accept `cmd_val=1` at cycle k → `s=1` in cycles k+1..k+4, `r=0` throughout; `s=r=0` in k+5..k+6; `done=1` in k+7; `q_model=1`, `q_known=1`.
- Two commands back-to-back (1 then 0), second presented in the `done` cycle → second accepted immediately; `r=1` in 4 cycles starting the next cycle; `q_model=0` after.
- `cmd_valid` held with a toggling `cmd_val` during PULSE → ignored; `cmd_ready=0` until `done`; the pulse matches the captured value.
- Assert `rst` in the 2nd pulse cycle → `s=r=0` next cycle, `q_known=0`, no `done`, FSM in IDLE.
- With `SR_DRV_SKIP_EN`, after completing a set, send 1 again → no `s` pulse, `done=1` next cycle. Send 1 straight after reset → the pulse is issued. A checker asserts `s&r` is never 1 in every scenario.
